// File: rtl/m_port_ultra_quickhull_defs.sv
// ----------------------------------------------------------------------------
// m_port_ultra_quickhull_defs
// Definitions shared by the quickhull processor and the hull streamer.
// Holds the default geometry of the packed hull vector and the streamer FSM
// state encoding.
//   MAX_POINTS : point slots in the packed hull vector
//   COORD_W    : bits per coordinate
//   PT_W       : bits per point, {x,y}
//   SIZE_W     : width of set size and point index
// ----------------------------------------------------------------------------
package m_port_ultra_quickhull_defs;

   localparam int MAX_POINTS = 256;
   localparam int COORD_W    = 8;
   localparam int PT_W       = 2 * COORD_W;
   localparam int SIZE_W     = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } hull_state_e;

endpackage

// File: rtl/m_port_ultra_bbox_accum.sv
// ----------------------------------------------------------------------------
// m_port_ultra_bbox_accum
// Running bounding box of the points streamed in one hull frame.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clear             : zero all extents (new frame accepted)
//   init              : load extents from the first point of a frame
//   update            : widen extents with the current point
//   x, y              : coordinates of the current point
//   min_x/max_x/min_y/max_y : accumulated extents
// Priority: clear > init > update.
// ----------------------------------------------------------------------------
module m_port_ultra_bbox_accum #(
   parameter int COORD_W = m_port_ultra_quickhull_defs::COORD_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               init,
   input  logic               update,
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   output logic [COORD_W-1:0] min_x,
   output logic [COORD_W-1:0] max_x,
   output logic [COORD_W-1:0] min_y,
   output logic [COORD_W-1:0] max_y
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_x <= '0;
         max_x <= '0;
         min_y <= '0;
         max_y <= '0;
      end else if (clear) begin
         min_x <= '0;
         max_x <= '0;
         min_y <= '0;
         max_y <= '0;
      end else if (init) begin
         min_x <= x;
         max_x <= x;
         min_y <= y;
         max_y <= y;
      end else if (update) begin
         if (x < min_x) min_x <= x;
         if (x > max_x) max_x <= x;
         if (y < min_y) min_y <= y;
         if (y > max_y) max_y <= y;
      end
   end

endmodule

// File: rtl/m_port_ultra_hull_streamer.sv
// ----------------------------------------------------------------------------
// m_port_ultra_hull_streamer
// Captures the packed quickhull result on a one-cycle hull_valid pulse and
// streams it out one point per beat over a valid/ready interface.
// Ports:
//   CLK100MHZ, CPU_RESETN : clock, asynchronous active-low reset
//   hull_valid            : 1-cycle pulse, convexPoints/convexSetSize valid
//   convexPoints          : point i at [PT_W*i +: PT_W], {x,y}
//   convexSetSize         : number of valid hull points
//   pt_valid/pt_ready     : output beat handshake
//   pt_data/pt_index      : current point and its index
//   pt_first/pt_last      : beat is index 0 / index size-1
//   busy                  : frame in progress (STREAM or DONE)
//   frame_done            : 1-cycle pulse after the last beat (or empty frame)
//   dropped               : sticky, hull_valid arrived while busy
//   bbox_*                : bounding box of the last frame
// Build option HULL_BBOX_EN: enables the bounding-box accumulator; without it
// the bbox ports are tied to zero.
// All outputs are registered.
// ----------------------------------------------------------------------------
module m_port_ultra_hull_streamer #(
   parameter  int MAX_POINTS = m_port_ultra_quickhull_defs::MAX_POINTS,
   parameter  int COORD_W    = m_port_ultra_quickhull_defs::COORD_W,
   parameter  int SIZE_W     = m_port_ultra_quickhull_defs::SIZE_W,
   localparam int PT_W       = 2 * COORD_W
) (
   input  logic                       CLK100MHZ,
   input  logic                       CPU_RESETN,
   input  logic                       hull_valid,
   input  logic [MAX_POINTS*PT_W-1:0] convexPoints,
   input  logic [SIZE_W-1:0]          convexSetSize,
   output logic                       pt_valid,
   input  logic                       pt_ready,
   output logic [PT_W-1:0]            pt_data,
   output logic [SIZE_W-1:0]          pt_index,
   output logic                       pt_first,
   output logic                       pt_last,
   output logic                       busy,
   output logic                       frame_done,
   output logic                       dropped,
   output logic [COORD_W-1:0]         bbox_min_x,
   output logic [COORD_W-1:0]         bbox_max_x,
   output logic [COORD_W-1:0]         bbox_min_y,
   output logic [COORD_W-1:0]         bbox_max_y,
   output logic                       bbox_valid
);

   import m_port_ultra_quickhull_defs::*;

   logic [PT_W-1:0]   in_pts   [MAX_POINTS];
   logic [PT_W-1:0]   shadow_q [MAX_POINTS];
   logic [SIZE_W-1:0] size_q;

   hull_state_e       state_q, state_d;
   logic              pt_valid_d, pt_first_d, pt_last_d;
   logic              busy_d, frame_done_d, dropped_d;
   logic [PT_W-1:0]   pt_data_d;
   logic [SIZE_W-1:0] pt_index_d;
   logic [SIZE_W-1:0] next_idx;
   logic              accept, capture, transfer;

   // Unpack the flat vector so the shadow copy is indexable by point number.
   for (genvar g = 0; g < MAX_POINTS; g++) begin : g_unpack
      assign in_pts[g] = convexPoints[PT_W*g +: PT_W];
   end

   assign transfer = pt_valid & pt_ready;
   assign next_idx = pt_index + 1'b1;
   // Any hull_valid seen in IDLE starts a frame, including an empty one.
   assign accept   = (state_q == ST_IDLE) && hull_valid;
   assign capture  = accept && (convexSetSize != '0);

   // NOTE: every variable gets its hold value first, so no branch leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      pt_valid_d   = pt_valid;
      pt_data_d    = pt_data;
      pt_index_d   = pt_index;
      pt_first_d   = pt_first;
      pt_last_d    = pt_last;
      busy_d       = busy;
      frame_done_d = 1'b0;
      dropped_d    = dropped;

      case (state_q)
         ST_IDLE: begin
            if (hull_valid) begin
               if (convexSetSize != '0) begin
                  // First beat comes straight from the input; the shadow copy
                  // is loaded on the same edge and serves every later beat.
                  state_d    = ST_STREAM;
                  pt_valid_d = 1'b1;
                  pt_data_d  = in_pts[0];
                  pt_index_d = '0;
                  pt_first_d = 1'b1;
                  pt_last_d  = (convexSetSize == SIZE_W'(1));
                  busy_d     = 1'b1;
               end else begin
                  frame_done_d = 1'b1;
               end
            end
         end

         ST_STREAM: begin
            if (hull_valid) dropped_d = 1'b1;
            if (transfer) begin
               if (pt_last) begin
                  state_d      = ST_DONE;
                  pt_valid_d   = 1'b0;
                  pt_data_d    = '0;
                  pt_index_d   = '0;
                  pt_first_d   = 1'b0;
                  pt_last_d    = 1'b0;
                  frame_done_d = 1'b1;
               end else begin
                  pt_data_d  = shadow_q[next_idx];
                  pt_index_d = next_idx;
                  pt_first_d = 1'b0;
                  pt_last_d  = (next_idx == size_q - 1'b1);
               end
            end
         end

         ST_DONE: begin
            if (hull_valid) dropped_d = 1'b1;
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d    = ST_IDLE;
            pt_valid_d = 1'b0;
            busy_d     = 1'b0;
         end
      endcase
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state_q    <= ST_IDLE;
         pt_valid   <= 1'b0;
         pt_data    <= '0;
         pt_index   <= '0;
         pt_first   <= 1'b0;
         pt_last    <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         dropped    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pt_valid   <= pt_valid_d;
         pt_data    <= pt_data_d;
         pt_index   <= pt_index_d;
         pt_first   <= pt_first_d;
         pt_last    <= pt_last_d;
         busy       <= busy_d;
         frame_done <= frame_done_d;
         dropped    <= dropped_d;
      end
   end

   // NOTE: the shadow array is reset even though it is storage, so no stale frame survives a reset.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         shadow_q <= '{default: '0};
         size_q   <= '0;
      end else if (capture) begin
         shadow_q <= in_pts;
         size_q   <= convexSetSize;
      end
   end

`ifdef HULL_BBOX_EN
   logic bbox_valid_q;

   m_port_ultra_bbox_accum #(
      .COORD_W (COORD_W)
   ) u_bbox (
      .clk    (CLK100MHZ),
      .rst_n  (CPU_RESETN),
      .clear  (accept),
      .init   (transfer && pt_first),
      .update (transfer && !pt_first),
      .x      (pt_data[PT_W-1:COORD_W]),
      .y      (pt_data[COORD_W-1:0]),
      .min_x  (bbox_min_x),
      .max_x  (bbox_max_x),
      .min_y  (bbox_min_y),
      .max_y  (bbox_max_y)
   );

   // Set on the same edge that raises frame_done; an empty frame only clears.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN)               bbox_valid_q <= 1'b0;
      else if (accept)               bbox_valid_q <= 1'b0;
      else if (transfer && pt_last)  bbox_valid_q <= 1'b1;
   end

   assign bbox_valid = bbox_valid_q;
`else
   assign bbox_min_x = '0;
   assign bbox_max_x = '0;
   assign bbox_min_y = '0;
   assign bbox_max_y = '0;
   assign bbox_valid = 1'b0;
`endif

endmodule

// File: tb/tb_m_port_ultra_hull_streamer.sv
// ----------------------------------------------------------------------------
// tb_m_port_ultra_hull_streamer
// Scoreboard bench: each issued frame pushes its expected beats and its
// expected frame_done record; a negedge monitor pops and compares whenever
// the DUT presents a beat or a frame_done pulse. Honours HULL_BBOX_EN.
// ----------------------------------------------------------------------------
module tb_m_port_ultra_hull_streamer;

   localparam int MAX_POINTS = 256;
   localparam int COORD_W    = 8;
   localparam int PT_W       = 16;
   localparam int SIZE_W     = 8;
   localparam int VEC_W      = MAX_POINTS * PT_W;

   logic                CLK100MHZ     = 1'b0;
   logic                CPU_RESETN    = 1'b0;
   logic                hull_valid    = 1'b0;
   logic [VEC_W-1:0]    convexPoints  = '0;
   logic [SIZE_W-1:0]   convexSetSize = '0;
   logic                pt_ready      = 1'b0;
   logic                pt_valid, pt_first, pt_last, busy, frame_done, dropped;
   logic [PT_W-1:0]     pt_data;
   logic [SIZE_W-1:0]   pt_index;
   logic [COORD_W-1:0]  bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;
   logic                bbox_valid;

   always #5 CLK100MHZ = ~CLK100MHZ;

   m_port_ultra_hull_streamer dut (
      .CLK100MHZ     (CLK100MHZ),
      .CPU_RESETN    (CPU_RESETN),
      .hull_valid    (hull_valid),
      .convexPoints  (convexPoints),
      .convexSetSize (convexSetSize),
      .pt_valid      (pt_valid),
      .pt_ready      (pt_ready),
      .pt_data       (pt_data),
      .pt_index      (pt_index),
      .pt_first      (pt_first),
      .pt_last       (pt_last),
      .busy          (busy),
      .frame_done    (frame_done),
      .dropped       (dropped),
      .bbox_min_x    (bbox_min_x),
      .bbox_max_x    (bbox_max_x),
      .bbox_min_y    (bbox_min_y),
      .bbox_max_y    (bbox_max_y),
      .bbox_valid    (bbox_valid)
   );

   typedef struct {
      logic [15:0] data;
      int          idx;
      bit          first;
      bit          last;
   } beat_t;

   typedef struct {
      bit          busy;
      bit          bvalid;
      logic [7:0]  mnx, mxx, mny, mxy;
   } fd_t;

   beat_t       beat_q[$];
   fd_t         fd_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   bit          rand_ready = 1'b0;
   logic [15:0] pts [MAX_POINTS];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: event occurred with nothing expected at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge CLK100MHZ);
      #1;
      if (rand_ready) pt_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < MAX_POINTS; i++) pts[i] = 16'($urandom);
   endtask

   task automatic load_points();
      for (int i = MAX_POINTS - 1; i >= 0; i--)
         convexPoints = {convexPoints[VEC_W-PT_W-1:0], pts[i]};
   endtask

   // Drive one hull_valid pulse and record what the stream must look like.
   task automatic issue_frame(input int size);
      fd_t   f;
      beat_t b;
      load_points();
      convexSetSize = SIZE_W'(size);
      hull_valid    = 1'b1;
      f.busy   = (size != 0);
      f.bvalid = (size != 0);
      f.mnx = 8'hFF; f.mxx = 8'h00; f.mny = 8'hFF; f.mxy = 8'h00;
      if (size == 0) begin
         f.mnx = 8'h00; f.mny = 8'h00;
      end
      for (int i = 0; i < size; i++) begin
         b.data  = pts[i];
         b.idx   = i;
         b.first = (i == 0);
         b.last  = (i == size - 1);
         beat_q.push_back(b);
         if (pts[i][15:8] < f.mnx) f.mnx = pts[i][15:8];
         if (pts[i][15:8] > f.mxx) f.mxx = pts[i][15:8];
         if (pts[i][7:0]  < f.mny) f.mny = pts[i][7:0];
         if (pts[i][7:0]  > f.mxy) f.mxy = pts[i][7:0];
      end
      fd_q.push_back(f);
      tick();
      hull_valid    = 1'b0;
      convexPoints  = ~convexPoints;
      convexSetSize = ~convexSetSize;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || beat_q.size() != 0 || fd_q.size() != 0) && n < 3000) begin
         tick();
         n++;
      end
      check("idle_timeout", 32'(n < 3000), 32'd1);
   endtask

   // Monitor: compares every presented beat and every frame_done pulse.
   initial begin : monitor
      beat_t b;
      fd_t   f;
      forever begin
         @(negedge CLK100MHZ);
         if (CPU_RESETN) begin
            if (pt_valid) begin
               if (beat_q.size() == 0) begin
                  fail("unexpected_beat");
               end else begin
                  b = beat_q[0];
                  check("beat_data",  32'(pt_data),  32'(b.data));
                  check("beat_index", 32'(pt_index), 32'(b.idx));
                  check("beat_first", 32'(pt_first), 32'(b.first));
                  check("beat_last",  32'(pt_last),  32'(b.last));
                  if (pt_ready) void'(beat_q.pop_front());
               end
            end
            if (frame_done) begin
               if (fd_q.size() == 0) begin
                  fail("unexpected_frame_done");
               end else begin
                  f = fd_q.pop_front();
                  check("done_busy", 32'(busy), 32'(f.busy));
                  check("done_beats_left", 32'(beat_q.size()), 32'd0);
`ifdef HULL_BBOX_EN
                  check("bbox_valid", 32'(bbox_valid), 32'(f.bvalid));
                  if (f.bvalid) begin
                     check("bbox_min_x", 32'(bbox_min_x), 32'(f.mnx));
                     check("bbox_max_x", 32'(bbox_max_x), 32'(f.mxx));
                     check("bbox_min_y", 32'(bbox_min_y), 32'(f.mny));
                     check("bbox_max_y", 32'(bbox_max_y), 32'(f.mxy));
                  end
`else
                  check("bbox_tied_off", 32'({bbox_valid, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y}), 32'd0);
`endif
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1);
   end

   initial begin : stimulus
      int size;
      int r;

      // Reset state
      tick();
      check("rst_pt_valid",   32'(pt_valid),   32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_dropped",    32'(dropped),    32'd0);
      check("rst_pt_data",    32'(pt_data),    32'd0);
      CPU_RESETN = 1'b1;
      tick();

      // 1: three points, ready always high, exact timing
      pt_ready = 1'b1;
      pts[0] = 16'h0102; pts[1] = 16'h0304; pts[2] = 16'h0506;
      issue_frame(3);
      check("t1_first_valid", 32'(pt_valid), 32'd1);
      check("t1_first_flag",  32'(pt_first), 32'd1);
      check("t1_first_data",  32'(pt_data),  32'h0102);
      check("t1_busy",        32'(busy),     32'd1);
      tick();
      check("t1_beat1_idx",   32'(pt_index), 32'd1);
      tick();
      check("t1_last_flag",   32'(pt_last),  32'd1);
      check("t1_last_data",   32'(pt_data),  32'h0506);
      tick();
      check("t1_frame_done",  32'(frame_done), 32'd1);
      check("t1_valid_drop",  32'(pt_valid),   32'd0);
      check("t1_busy_done",   32'(busy),       32'd1);
      tick();
      check("t1_busy_low",    32'(busy),       32'd0);
      check("t1_done_pulse",  32'(frame_done), 32'd0);
      check("t1_dropped",     32'(dropped),    32'd0);
      wait_idle();

      // 2: back-pressure for two cycles on beat 1
      pts[0] = 16'h0102; pts[1] = 16'h0304; pts[2] = 16'h0506;
      issue_frame(3);
      tick();
      pt_ready = 1'b0;
      check("t2_hold_idx_a", 32'(pt_index), 32'd1);
      tick();
      check("t2_hold_idx_b", 32'(pt_index), 32'd1);
      tick();
      check("t2_hold_data",  32'(pt_data),  32'h0304);
      pt_ready = 1'b1;
      tick();
      check("t2_after_hold", 32'(pt_data),  32'h0506);
      wait_idle();

      // 3: empty frame
      issue_frame(0);
      check("t3_frame_done", 32'(frame_done), 32'd1);
      check("t3_busy",       32'(busy),       32'd0);
      check("t3_no_valid",   32'(pt_valid),   32'd0);
      tick();
      check("t3_busy_after", 32'(busy),       32'd0);
      wait_idle();

      // 6: bounding-box frame
      pts[0] = 16'h0A05; pts[1] = 16'h0214; pts[2] = 16'h0F01;
      issue_frame(3);
      wait_idle();
`ifdef HULL_BBOX_EN
      check("t6_bbox_held", 32'({bbox_valid, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y}),
            32'({1'b1, 8'h02, 8'h0F, 8'h01, 8'h14}));
`else
      check("t6_bbox_zero", 32'({bbox_valid, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y}), 32'd0);
`endif

      // 4: second hull_valid during STREAM is dropped
      fill_random();
      pt_ready = 1'b0;
      issue_frame(6);
      tick();
      fill_random();
      load_points();
      convexSetSize = 8'd9;
      hull_valid    = 1'b1;
      tick();
      hull_valid = 1'b0;
      check("t4_dropped", 32'(dropped), 32'd1);
      pt_ready = 1'b1;
      wait_idle();
      fill_random();
      issue_frame(2);
      wait_idle();
      check("t4_dropped_sticky", 32'(dropped), 32'd1);

      // 5: reset in the middle of a frame
      fill_random();
      pt_ready = 1'b1;
      issue_frame(4);
      tick();
      CPU_RESETN = 1'b0;
      #1;
      check("t5_rst_outputs",
            32'({pt_valid, pt_first, pt_last, busy, frame_done, dropped, bbox_valid}), 32'd0);
      check("t5_rst_data_idx", 32'({pt_data, pt_index}), 32'd0);
      beat_q.delete();
      fd_q.delete();
      tick();
      tick();
      CPU_RESETN = 1'b1;
      tick();
      check("t5_idle_after", 32'(busy), 32'd0);
      fill_random();
      issue_frame(5);
      wait_idle();

      // Randomized frames with random back-pressure
      rand_ready = 1'b1;
      for (int k = 0; k < 25; k++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      size = 0;
         else if (r == 1) size = 1;
         else if (r == 2) size = 255;
         else             size = $urandom_range(2, 12);
         fill_random();
         issue_frame(size);
         wait_idle();
      end
      rand_ready = 1'b0;

      check("end_beats_drained", 32'(beat_q.size()), 32'd0);
      check("end_done_drained",  32'(fd_q.size()),   32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
